csr_trap_unit: RTL and testbench
================================

Name: csr_trap_unit

Overview:
- Machine-mode CSR file and trap controller for the 3-stage RV32 core.
- Generalises the single-interrupt CSR block:
  - parametrised platform interrupt lines
  - full CSRRW/CSRRS/CSRRC semantics
  - MIE/MPIE save/restore
  - priority-resolved interrupts and exceptions
  - vectored mtvec
  - 64-bit mcycle counter
- Sits beside the execute stage; drives the fetch redirect on trap or mret.

Parameters:
- XLEN, 32, data width. Only 32 is supported.
- NUM_PLAT_IRQ, 4, platform interrupt lines mapped to mip/mie bits [16+i]. Legal range 0..16.
- RESET_MTVEC, 32'h0000_0000, mtvec value after reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- pc_i  in  32  PC of the instruction in execute
- csr_addr_i  in  12  CSR address
- csr_op_i  in  2  00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits)
- csr_wdata_i  in  32  rs1 value or zimm operand
- csr_rdata_o  out  32  old CSR value, combinational
- illegal_csr_o  out  1  access to an unimplemented address, combinational
- sw_irq_i  in  1  software interrupt, mip[3]
- timer_irq_i  in  1  timer interrupt, mip[7]
- ext_irq_i  in  1  external interrupt, mip[11]
- plat_irq_i  in  NUM_PLAT_IRQ  platform interrupts, mip[16+i]
- exc_i  in  1  synchronous exception on the instruction in execute
- exc_cause_i  in  5  exception code
- is_mret_i  in  1  mret in execute
- trap_taken_o  out  1  one-cycle redirect strobe, registered
- trap_pc_o  out  32  redirect target, registered

Behaviour:
- Reset values:
  - mstatus = 32'h0000_1800 (MPP=11, MIE=0, MPIE=0)
  - mie, mepc, mcause, mscratch, mcycle = 0
  - mtvec = RESET_MTVEC
  - mip = 0
  - trap_taken_o = 0, trap_pc_o = 0
  - FSM in RUN
- Implemented CSRs: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mip 344, mcycle B00, mcycleh B80.
- Other addresses with op≠00:
  - illegal_csr_o = 1
  - rdata = 0
  - no state change
- Write value:
  - RW: new = wdata
  - RS: new = old | wdata
  - RC: new = old & ~wdata
  - RS/RC write even when wdata = 0; this is harmless.
- WARL rules:
  - mstatus: only bits 3 (MIE) and 7 (MPIE) writable; MPP reads 11; all other bits read 0.
  - mepc: bits [1:0] forced 0.
  - mtvec: bit 1 forced 0.
  - mie: only bits 3, 7, 11 and [16+NUM_PLAT_IRQ-1:16] writable.
  - mip: read-only; writes are ignored and are not illegal.
- mip sampling:
  - Interrupt inputs are level-sensitive.
  - They are registered into mip each cycle, giving 1 cycle of latency.
- mcycle:
  - 64 bits, increments every cycle and wraps 2^64-1 -> 0.
  - A CSR write to mcycle or mcycleh replaces that half for the cycle. The written value is stored and is not incremented.
- Event priority in a cycle (evaluated only in state RUN):
  - 1st: exc_i
  - 2nd: is_mret_i
  - 3rd: interrupt. Taken when mstatus.MIE=1 and (mip & mie) ≠ 0.
- Interrupt priority among pending-enabled sources:
  - MEI(11) > MSI(3) > MTI(7) > plat[0] > ... > plat[N-1]
  - Platform cause code = 16+i.
- Trap entry (exception or interrupt), at the clock edge:
  - mepc <= pc_i
  - mcause <= {interrupt bit, 26'b0, code}
  - MPIE <= MIE
  - MIE <= 0
- Trap target:
  - Exceptions, and all traps when mtvec[0]=0: {mtvec[31:2],2'b00}.
  - Interrupts with mtvec[0]=1: {mtvec[31:2],2'b00} + 4*code.
- mret, at the clock edge:
  - MIE <= MPIE
  - MPIE <= 1
  - target = mepc
- A CSR write in the same cycle as a trap or mret is dropped. Trap/mret state updates win.
- FSM:
  - RUN -> REDIRECT on any trap or mret.
  - REDIRECT -> RUN unconditionally after 1 cycle.
  - In REDIRECT: trap_taken_o=1, trap_pc_o=target; exc_i, is_mret_i and interrupts are ignored; CSR writes are dropped.
  - trap_taken_o is high for exactly one cycle per event.
- Latency: event seen in cycle N -> trap_taken_o high in cycle N+1.
- Asynchronous reset mid-REDIRECT: returns to RUN with trap_taken_o=0 immediately.

Decomposition:
- csr_pkg holds:
  - CSR address constants
  - csr_op_e enum
  - cause code constants (MSI=3, MTI=7, MEI=11, PLAT_BASE=16)
  - mstatus bit indices
  - fsm_state_e {RUN, REDIRECT}
- Sub-module csr_irq_prio: combinational priority encoder taking the pending&enabled vector. Outputs a valid flag and a 5-bit cause code.

Test Plan:
- Reset -> read 300 gives 0x1800; 305 gives RESET_MTVEC; 342 gives 0. Read 7C0 -> illegal_csr_o=1, rdata=0.
- RW 300 = 0xFFFF_FFFF -> reads 0x1888. Then RC 300 = 0x8 -> reads 0x1880.
- mtvec=0x100, mie=0x80, MIE=1, timer_irq_i=1 with pc_i=0x40:
  - trap_taken_o pulses 2 cycles after timer_irq_i rises, with trap_pc_o=0x100.
  - mcause=0x8000_0007, mepc=0x40, mstatus reads 0x1880.
- mtvec=0x101, mie enabling bits 11 and 16, ext and plat[0] raised together:
  - trap_pc_o=0x12C, mcause=0x8000_000B.
  - mret -> trap_pc_o=mepc, MIE=1; the next interrupt is taken only after the REDIRECT cycle.
- exc_i with cause 2 and is_mret_i asserted while an interrupt is pending, plus RW 340 in the same cycle:
  - mcause=2 and trap_pc_o=mtvec base.
  - mscratch is unchanged.
- Write mcycle=0xFFFF_FFFF and mcycleh=0xFFFF_FFFF:
  - reads hold those values for the write cycle, then wrap to 0.
- Assert reset during REDIRECT -> trap_taken_o low immediately.

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, op/cause codes and FSM states for the trap unit
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  localparam logic [4:0] CAUSE_MSI       = 5'd3;
  localparam logic [4:0] CAUSE_MTI       = 5'd7;
  localparam logic [4:0] CAUSE_MEI       = 5'd11;
  localparam logic [4:0] CAUSE_PLAT_BASE = 5'd16;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam logic [31:0] MSTATUS_MPP_BITS = 32'h0000_1800;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } fsm_state_e;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (op)
      CSR_RW:  return wdata;
      CSR_RS:  return old_val | wdata;
      CSR_RC:  return old_val & ~wdata;
      default: return old_val;
    endcase
  endfunction
endpackage

// File: rtl/csr_irq_prio.sv
// rtl/csr_irq_prio.sv - fixed-priority interrupt selector: MEI > MSI > MTI > plat[0] > ... > plat[N-1]
module csr_irq_prio #(
  parameter int NUM_PLAT_IRQ = 4
) (
  input  logic                    msi_i,
  input  logic                    mti_i,
  input  logic                    mei_i,
  input  logic [NUM_PLAT_IRQ-1:0] plat_i,
  output logic                    valid_o,
  output logic [4:0]              cause_o
);
  import csr_pkg::*;

  always_comb begin
    valid_o = 1'b0;
    cause_o = 5'd0;
    // Scan from the weakest source upward so each stronger hit overrides.
    for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
      if (plat_i[i]) begin
        valid_o = 1'b1;
        cause_o = CAUSE_PLAT_BASE + 5'(i);
      end
    end
    if (mti_i) begin
      valid_o = 1'b1;
      cause_o = CAUSE_MTI;
    end
    if (msi_i) begin
      valid_o = 1'b1;
      cause_o = CAUSE_MSI;
    end
    if (mei_i) begin
      valid_o = 1'b1;
      cause_o = CAUSE_MEI;
    end
  end
endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file and trap/mret redirect controller
module csr_trap_unit #(
  parameter int          XLEN         = 32,
  parameter int          NUM_PLAT_IRQ = 4,
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [11:0]             csr_addr_i,
  input  logic [1:0]              csr_op_i,
  input  logic [XLEN-1:0]         csr_wdata_i,
  output logic [XLEN-1:0]         csr_rdata_o,
  output logic                    illegal_csr_o,
  input  logic                    sw_irq_i,
  input  logic                    timer_irq_i,
  input  logic                    ext_irq_i,
  input  logic [NUM_PLAT_IRQ-1:0] plat_irq_i,
  input  logic                    exc_i,
  input  logic [4:0]              exc_cause_i,
  input  logic                    is_mret_i,
  output logic                    trap_taken_o,
  output logic [XLEN-1:0]         trap_pc_o
);
  import csr_pkg::*;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888 | (((32'd1 << NUM_PLAT_IRQ) - 32'd1) << 16);

  fsm_state_e  state_q, state_d;
  logic        mie_bit_q, mie_bit_d, mpie_q, mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mip_q, mip_d, trap_pc_q, trap_pc_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [31:0] rdata, mstatus_rd, wr_val, trap_base;
  logic        hit, csr_we, irq_valid;
  logic [4:0]  irq_cause;

  assign mstatus_rd = MSTATUS_MPP_BITS | ({31'b0, mpie_q} << MSTATUS_MPIE_BIT)
                    | ({31'b0, mie_bit_q} << MSTATUS_MIE_BIT);
  assign trap_base  = {mtvec_q[31:2], 2'b00};

  always_comb begin
    rdata = 32'h0;
    hit   = 1'b1;
    case (csr_addr_i)
      CSR_MSTATUS:  rdata = mstatus_rd;
      CSR_MIE:      rdata = mie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MIP:      rdata = mip_q;
      CSR_MCYCLE:   rdata = mcycle_q[31:0];
      CSR_MCYCLEH:  rdata = mcycle_q[63:32];
      default:      hit = 1'b0;
    endcase
  end

  assign csr_rdata_o   = rdata;
  assign illegal_csr_o = !hit && (csr_op_i != CSR_NONE);
  assign trap_taken_o  = (state_q == REDIRECT);
  assign trap_pc_o     = trap_pc_q;

  always_comb begin
    mip_d     = 32'h0;
    mip_d[3]  = sw_irq_i;
    mip_d[7]  = timer_irq_i;
    mip_d[11] = ext_irq_i;
    for (int i = 0; i < NUM_PLAT_IRQ; i++) mip_d[16+i] = plat_irq_i[i];
  end

  csr_irq_prio #(.NUM_PLAT_IRQ(NUM_PLAT_IRQ)) u_prio (
    .msi_i   (mip_q[3] & mie_q[3]),
    .mti_i   (mip_q[7] & mie_q[7]),
    .mei_i   (mip_q[11] & mie_q[11]),
    .plat_i  (mip_q[16 +: NUM_PLAT_IRQ] & mie_q[16 +: NUM_PLAT_IRQ]),
    .valid_o (irq_valid),
    .cause_o (irq_cause)
  );

  always_comb begin
    state_d    = RUN;
    mie_bit_d  = mie_bit_q;
    mpie_d     = mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    trap_pc_d  = trap_pc_q;
    mcycle_d   = mcycle_q + 64'd1;
    wr_val     = csr_apply(csr_op_e'(csr_op_i), rdata, csr_wdata_i);
    csr_we     = (state_q == RUN) && (csr_op_i != CSR_NONE) && hit;

    // Trap and mret updates own the cycle, so any concurrent CSR write is dropped.
    if (state_q == RUN) begin
      if (exc_i) begin
        state_d   = REDIRECT;
        csr_we    = 1'b0;
        mepc_d    = pc_i;
        mcause_d  = {27'b0, exc_cause_i};
        mpie_d    = mie_bit_q;
        mie_bit_d = 1'b0;
        trap_pc_d = trap_base;
      end else if (is_mret_i) begin
        state_d   = REDIRECT;
        csr_we    = 1'b0;
        mie_bit_d = mpie_q;
        mpie_d    = 1'b1;
        trap_pc_d = mepc_q;
      end else if (mie_bit_q && irq_valid) begin
        state_d   = REDIRECT;
        csr_we    = 1'b0;
        mepc_d    = pc_i;
        mcause_d  = {1'b1, 26'b0, irq_cause};
        mpie_d    = mie_bit_q;
        mie_bit_d = 1'b0;
        trap_pc_d = mtvec_q[0] ? trap_base + {25'b0, irq_cause, 2'b00} : trap_base;
      end
    end

    if (csr_we) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mie_bit_d = wr_val[MSTATUS_MIE_BIT];
          mpie_d    = wr_val[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_d = wr_val & MIE_MASK;
        CSR_MTVEC:    mtvec_d = {wr_val[31:2], 1'b0, wr_val[0]};
        CSR_MSCRATCH: mscratch_d = wr_val;
        CSR_MEPC:     mepc_d = {wr_val[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d = wr_val;
        CSR_MCYCLE:   mcycle_d[31:0] = wr_val;
        CSR_MCYCLEH:  mcycle_d[63:32] = wr_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      mie_bit_q  <= 1'b0;
      mpie_q     <= 1'b0;
      mie_q      <= 32'h0;
      mtvec_q    <= RESET_MTVEC;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mip_q      <= 32'h0;
      mcycle_q   <= 64'h0;
      trap_pc_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      mie_bit_q  <= mie_bit_d;
      mpie_q     <= mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mip_q      <= mip_d;
      mcycle_q   <= mcycle_d;
      trap_pc_q  <= trap_pc_d;
    end
  end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - self-checking bench for csr_trap_unit against a behavioural model
module tb_csr_trap_unit;
  localparam int          NP     = 4;
  localparam logic [31:0] RMTVEC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   pc_i = '0, csr_wdata_i = '0, csr_rdata_o, trap_pc_o;
  logic [11:0]   csr_addr_i = '0;
  logic [1:0]    csr_op_i = '0;
  logic          illegal_csr_o, trap_taken_o;
  logic          sw_irq_i = 0, timer_irq_i = 0, ext_irq_i = 0, exc_i = 0, is_mret_i = 0;
  logic [NP-1:0] plat_irq_i = '0;
  logic [4:0]    exc_cause_i = '0;

  csr_trap_unit #(.XLEN(32), .NUM_PLAT_IRQ(NP), .RESET_MTVEC(RMTVEC)) dut (
    .clk(clk), .reset(reset), .pc_i(pc_i), .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .illegal_csr_o(illegal_csr_o),
    .sw_irq_i(sw_irq_i), .timer_irq_i(timer_irq_i), .ext_irq_i(ext_irq_i),
    .plat_irq_i(plat_irq_i), .exc_i(exc_i), .exc_cause_i(exc_cause_i), .is_mret_i(is_mret_i),
    .trap_taken_o(trap_taken_o), .trap_pc_o(trap_pc_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model state
  logic        m_mie, m_mpie, m_redir;
  logic [31:0] m_mie_r, m_mtvec, m_mepc, m_mcause, m_mscratch, m_mip, m_tpc, mie_mask;
  logic [63:0] m_cyc;
  int          prio[$];

  function automatic logic [32:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0)};
      12'h304: return {1'b1, m_mie_r};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_mscratch};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'h344: return {1'b1, m_mip};
      12'hB00: return {1'b1, m_cyc[31:0]};
      12'hB80: return {1'b1, m_cyc[63:32]};
      default: return 33'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic [32:0] rd;
    logic [31:0] nv, new_mip;
    logic        wr;
    int          code;
    if (reset) begin
      m_mie = 0; m_mpie = 0; m_redir = 0;
      m_mie_r = 0; m_mtvec = RMTVEC; m_mepc = 0; m_mcause = 0; m_mscratch = 0;
      m_mip = 0; m_tpc = 0; m_cyc = 0;
    end else begin
      new_mip = 0;
      new_mip[3] = sw_irq_i; new_mip[7] = timer_irq_i; new_mip[11] = ext_irq_i;
      for (int i = 0; i < NP; i++) new_mip[16+i] = plat_irq_i[i];
      rd = m_read(csr_addr_i);
      case (csr_op_i)
        2'b01:   nv = csr_wdata_i;
        2'b10:   nv = rd[31:0] | csr_wdata_i;
        2'b11:   nv = rd[31:0] & ~csr_wdata_i;
        default: nv = 0;
      endcase
      wr = (csr_op_i != 2'b00) && rd[32];
      if (m_redir) begin
        m_redir = 0;
        wr = 0;
      end else begin
        code = -1;
        if (m_mie)
          foreach (prio[k])
            if (code < 0 && m_mip[prio[k]] && m_mie_r[prio[k]]) code = prio[k];
        if (exc_i) begin
          m_mepc = pc_i; m_mcause = {27'b0, exc_cause_i};
          m_mpie = m_mie; m_mie = 0;
          m_tpc = m_mtvec & ~32'h3; m_redir = 1; wr = 0;
        end else if (is_mret_i) begin
          m_mie = m_mpie; m_mpie = 1;
          m_tpc = m_mepc; m_redir = 1; wr = 0;
        end else if (code >= 0) begin
          m_mepc = pc_i; m_mcause = 32'h8000_0000 | 32'(code);
          m_mpie = m_mie; m_mie = 0;
          m_tpc = (m_mtvec & ~32'h3) + (m_mtvec[0] ? 32'(4 * code) : 32'h0);
          m_redir = 1; wr = 0;
        end
      end
      m_cyc = m_cyc + 64'd1;
      if (wr) begin
        case (csr_addr_i)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: m_mie_r = nv & mie_mask;
          12'h305: m_mtvec = nv & ~32'h2;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~32'h3;
          12'h342: m_mcause = nv;
          12'hB00: m_cyc[31:0] = nv;
          12'hB80: m_cyc[63:32] = nv;
          default: ;
        endcase
      end
      m_mip = new_mip;
    end
  end

  always @(negedge clk) begin : cmp
    logic [32:0] rd;
    if (!reset) begin
      rd = m_read(csr_addr_i);
      check("rdata", csr_rdata_o, rd[31:0]);
      check("illegal", {31'b0, illegal_csr_o}, {31'b0, (csr_op_i != 2'b00) && !rd[32]});
      check("trap_taken", {31'b0, trap_taken_o}, {31'b0, m_redir});
      check("trap_pc", trap_pc_o, m_tpc);
    end
  end

  task automatic cyc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    mie_mask = 32'h888;
    for (int i = 0; i < NP; i++) mie_mask[16+i] = 1'b1;
    prio.push_back(11); prio.push_back(3); prio.push_back(7);
    for (int i = 0; i < NP; i++) prio.push_back(16 + i);
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // Reset values and illegal address
    cyc(2'b00, 12'h300, 0); check("rst_mstatus", csr_rdata_o, 32'h1800);
    cyc(2'b00, 12'h305, 0); check("rst_mtvec", csr_rdata_o, RMTVEC);
    cyc(2'b00, 12'h342, 0); check("rst_mcause", csr_rdata_o, 32'h0);
    cyc(2'b10, 12'h7C0, 0);
    check("illegal_7c0", {31'b0, illegal_csr_o}, 32'h1);
    check("illegal_rdata", csr_rdata_o, 32'h0);

    // mstatus WARL
    cyc(2'b01, 12'h300, 32'hFFFF_FFFF);
    cyc(2'b00, 12'h300, 0); check("mstatus_rw", csr_rdata_o, 32'h1888);
    cyc(2'b11, 12'h300, 32'h8);
    cyc(2'b00, 12'h300, 0); check("mstatus_rc", csr_rdata_o, 32'h1880);
    cyc(2'b01, 12'h340, 32'h1234);

    // Direct-mode timer interrupt
    cyc(2'b01, 12'h305, 32'h100);
    cyc(2'b01, 12'h304, 32'h80);
    cyc(2'b10, 12'h300, 32'h8); pc_i = 32'h40;
    cyc(2'b00, 12'h300, 0); timer_irq_i = 1;
    cyc(2'b00, 12'h300, 0); check("tmr_not_yet", {31'b0, trap_taken_o}, 32'h0);
    cyc(2'b00, 12'h300, 0); timer_irq_i = 0;
    check("tmr_taken", {31'b0, trap_taken_o}, 32'h1);
    check("tmr_pc", trap_pc_o, 32'h100);
    cyc(2'b00, 12'h342, 0);
    check("tmr_one_cycle", {31'b0, trap_taken_o}, 32'h0);
    check("tmr_mcause", csr_rdata_o, 32'h8000_0007);
    cyc(2'b00, 12'h341, 0); check("tmr_mepc", csr_rdata_o, 32'h40);
    cyc(2'b00, 12'h300, 0); check("tmr_mstatus", csr_rdata_o, 32'h1880);

    // Vectored mode, MEI beats plat[0]; mret and post-redirect interrupt
    cyc(2'b01, 12'h305, 32'h101);
    cyc(2'b01, 12'h304, 32'h0001_0800); pc_i = 32'h200;
    cyc(2'b10, 12'h300, 32'h8);
    cyc(2'b00, 12'h300, 0); ext_irq_i = 1; plat_irq_i = 4'b0001;
    cyc(2'b00, 12'h300, 0); ext_irq_i = 0; plat_irq_i = 4'b0000;
    cyc(2'b00, 12'h342, 0);
    check("vec_pc", trap_pc_o, 32'h12C);
    check("vec_mcause", csr_rdata_o, 32'h8000_000B);
    cyc(2'b00, 12'h300, 0); is_mret_i = 1; ext_irq_i = 1;
    cyc(2'b00, 12'h300, 0); is_mret_i = 0;
    check("mret_taken", {31'b0, trap_taken_o}, 32'h1);
    check("mret_pc", trap_pc_o, 32'h200);
    check("mret_mstatus", csr_rdata_o, 32'h1888);
    cyc(2'b00, 12'h300, 0);
    check("redirect_blocks_irq", {31'b0, trap_taken_o}, 32'h0);
    cyc(2'b00, 12'h342, 0); ext_irq_i = 0;
    check("irq_after_mret", {31'b0, trap_taken_o}, 32'h1);
    check("irq_after_mret_pc", trap_pc_o, 32'h12C);

    // Exception beats mret and pending interrupt; concurrent write dropped
    cyc(2'b00, 12'h300, 0); ext_irq_i = 1;
    cyc(2'b10, 12'h300, 32'h8);
    cyc(2'b01, 12'h340, 32'hDEAD); exc_i = 1; exc_cause_i = 5'd2; is_mret_i = 1; pc_i = 32'h300;
    cyc(2'b00, 12'h342, 0); exc_i = 0; is_mret_i = 0; ext_irq_i = 0;
    check("exc_pc", trap_pc_o, 32'h100);
    check("exc_mcause", csr_rdata_o, 32'h2);
    cyc(2'b00, 12'h340, 0); check("exc_mscratch", csr_rdata_o, 32'h1234);
    cyc(2'b00, 12'h341, 0); check("exc_mepc", csr_rdata_o, 32'h300);

    // mcycle wrap
    cyc(2'b01, 12'hB80, 32'hFFFF_FFFF);
    cyc(2'b01, 12'hB00, 32'hFFFF_FFFF);
    cyc(2'b00, 12'hB00, 0); check("mcycle_held", csr_rdata_o, 32'hFFFF_FFFF);
    cyc(2'b00, 12'hB80, 0); check("mcycleh_wrap", csr_rdata_o, 32'h0);

    // Asynchronous reset during REDIRECT
    cyc(2'b00, 12'h300, 0); exc_i = 1; exc_cause_i = 5'd5;
    cyc(2'b00, 12'h300, 0); exc_i = 0;
    check("pre_reset_taken", {31'b0, trap_taken_o}, 32'h1);
    #1 reset = 1;
    #1 check("reset_taken", {31'b0, trap_taken_o}, 32'h0);
    check("reset_pc", trap_pc_o, 32'h0);
    @(posedge clk); #1 reset = 0;
    cyc(2'b00, 12'h300, 0); check("post_reset_mstatus", csr_rdata_o, 32'h1800);
    cyc(2'b00, 12'h305, 0);
    cyc(2'b00, 12'h300, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
